llki_tlul_err_gate: RTL and testbench
=====================================

# llki_tlul_err_gate

Request gate placed directly downstream of the LLKI TL-UL error checker (`tlul_err`). It consumes that checker's `err_o` for the current host A-channel beat. Legal requests are forwarded to the device port. Illegal requests are sunk and answered locally with a `d_error` response, so that malformed traffic never reaches LLKI register or KL devices. Response order on the host D channel is preserved by serializing error responses behind all outstanding device transactions.

## Interface
- `MaxOutstanding`, default 1: maximum device requests in flight (1–15).
- `clk_i` input 1: clock.
- `rst_ni` input 1: synchronous, active-low reset.
- `tl_h_i` input `tl_h2d_t`: host request (A channel) and host `d_ready`.
- `tl_h_o` output `tl_d2h_t`: host response (D channel) and host `a_ready`.
- `err_i` input 1: `err_o` from `tlul_err`, evaluated combinationally on `tl_h_i`; meaningful only while `tl_h_i.a_valid`.
- `tl_d_o` output `tl_h2d_t`: device request.
- `tl_d_i` input `tl_d2h_t`: device response.

## Operation
- State: `cnt` (outstanding device requests, `$clog2(MaxOutstanding+1)` bits), `err_pending` flag, and the captured `err_source`, `err_size`, `err_is_get`.
- `stall = err_pending | (cnt == MaxOutstanding)`.
- Good beat (`a_valid & ~err_i`):
  - `tl_d_o.a_valid = ~stall`.
  - `tl_h_o.a_ready = tl_d_i.a_ready & ~stall`.
  - All other A fields pass through unmodified.
- Bad beat (`a_valid & err_i`):
  - `tl_d_o.a_valid = 0`.
  - `tl_h_o.a_ready = ~err_pending & (cnt == 0)`.
  - On handshake: set `err_pending`, capture `a_source`, `a_size`, and `err_is_get = (a_opcode == Get)`.
- `tl_d_o.a_valid` is 0 whenever `tl_h_i.a_valid` is 0.
- D channel when `err_pending = 1`:
  - `tl_h_o.d_valid = 1`; `d_opcode = AccessAckData` if `err_is_get`, else `AccessAck`.
  - `d_error = 1`; `d_data` all-ones; `d_size`, `d_source` from the captured values.
  - `d_param`, `d_sink`, `d_user` are 0.
  - `tl_d_o.d_ready = 0`.
- D channel when `err_pending = 0`: all device D fields pass through, and `tl_d_o.d_ready = tl_h_i.d_ready`.
- `err_pending` clears on the host D handshake (`d_valid & d_ready`).
- `cnt` update rules:
  - +1 on a device A handshake; −1 on a device D handshake; unchanged if both occur in the same cycle.
  - A device D handshake with `cnt == 0` is a protocol violation: `cnt` holds at 0 and the response is still forwarded.
  - Assertions: `cnt` never exceeds `MaxOutstanding`; no device `d_valid` while `cnt == 0`.
- No state machine beyond `cnt` and `err_pending`. Unknown opcodes are treated like any `err_i` beat.

## Timing
- Reset values: `err_pending = 0`, `cnt = 0`.
  - During reset, `tl_h_o.d_valid` mirrors `tl_d_i.d_valid`; all other `tl_h_o` D fields mirror the device.
  - `tl_h_o.a_ready` and `tl_d_o.a_valid` follow the combinational rules above with `stall = 0`.
- Good path has zero added latency: `a_ready` and `a_valid` are combinational through `err_i` and `tl_d_i.a_ready`.
- Error response: accepted in cycle N; `d_valid = 1` from N+1; held stable until `d_ready`.
- The cycle in which the error response retires still has `err_pending = 1`, so no new beat is accepted in it. Earliest next acceptance is the following cycle.
- A bad beat waits for `cnt == 0`, so it is always answered after all earlier device responses.
- Reset asserted mid-operation clears `err_pending` and `cnt` at the next edge; any pending error response is discarded. The device must be reset in the same cycle.

## Test plan
- **Good Get forwarded.** Get, size 3, addr 0x10, mask 0xFF, `err_i = 0`, `source = 2`.
  - Expect `tl_d_o.a_valid = 1` in the same cycle, and `cnt` goes 0→1.
  - Device returns `0xDEADBEEF_CAFEF00D`; host sees that data with `d_error = 0`, and `cnt` goes back to 0.
- **Bad Get sunk.** Get, size 3, addr 0x4, `err_i = 1`, `source = 5`.
  - Expect `tl_d_o.a_valid = 0` and `a_ready = 1`.
  - Next cycle: `d_valid = 1`, `AccessAckData`, `d_error = 1`, `d_source = 5`, `d_size = 3`, `d_data = 0xFFFF_FFFF_FFFF_FFFF`.
  - Hold `d_ready = 0` for 4 cycles: response stays stable and a new valid beat sees `a_ready = 0`. Raise `d_ready`: response retires, and the new beat is accepted the cycle after.
- **Bad PutFullData.** PutFullData, size 3, mask 0x0F, `err_i = 1`. Expect `AccessAck` with `d_error = 1`, `source` echoed, and nothing reaching the device.
- **Ordering.** Good Put outstanding with the device delaying its response 3 cycles, then a bad beat presented.
  - Expect `a_ready = 0` until the device D handshake, then acceptance.
  - Host D order: device response first, error response second.
- **Outstanding limit.** `MaxOutstanding = 2`, device `a_ready = 1`, device never responds. Expect the third good beat stalled with `tl_d_o.a_valid = 0` and `cnt = 2`.
- **Reset mid-error.** Assert reset while `err_pending = 1` and `d_ready = 0`. After one edge, expect `tl_h_o.d_valid` to follow `tl_d_i.d_valid` (0) and `cnt = 0`.

Source files
------------

// File: rtl/llki_tlul_err_gate.sv
// llki_tlul_err_gate: sits behind the TL-UL error checker. Legal beats go to the
// device port. Illegal beats are absorbed and answered here with d_error set.
// Error responses wait until every device transaction has completed, so the
// host always sees its responses in request order.

// TL-UL channel structures (64-bit data bus) shared by the gate and its users
typedef struct packed {
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic [15:0] a_user;
  logic        d_ready;
} tl_h2d_t;

typedef struct packed {
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [63:0] d_data;
  logic [15:0] d_user;
  logic        d_error;
  logic        a_ready;
} tl_d2h_t;

localparam logic [2:0] TlGet           = 3'h4;
localparam logic [2:0] TlAccessAck     = 3'h0;
localparam logic [2:0] TlAccessAckData = 3'h1;

module llki_tlul_err_gate #(
  parameter int unsigned MaxOutstanding = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  input  logic    err_i,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt;
  logic            err_pending;
  logic [7:0]      err_source;
  logic [1:0]      err_size;
  logic            err_is_get;

  logic cnt_zero;
  logic stall;
  logic good_beat;
  logic bad_beat;
  logic host_a_ready;
  logic dev_a_valid;
  logic dev_d_ready;
  logic host_d_valid;
  logic dev_a_hs;
  logic dev_d_hs;
  logic bad_accept;
  logic host_d_hs;

  assign cnt_zero  = (cnt == '0);
  assign stall     = err_pending | (cnt == CntMax);
  assign good_beat = tl_h_i.a_valid & ~err_i;
  assign bad_beat  = tl_h_i.a_valid & err_i;

  // A bad beat may only be taken once all device traffic has drained
  always_comb begin
    dev_a_valid  = good_beat & ~stall;
    dev_d_ready  = tl_h_i.d_ready & ~err_pending;
    host_d_valid = err_pending | tl_d_i.d_valid;
    if (bad_beat) begin
      host_a_ready = ~err_pending & cnt_zero;
    end else begin
      host_a_ready = tl_d_i.a_ready & ~stall;
    end
  end

  assign dev_a_hs   = dev_a_valid & tl_d_i.a_ready;
  assign dev_d_hs   = tl_d_i.d_valid & dev_d_ready;
  assign bad_accept = bad_beat & host_a_ready;
  assign host_d_hs  = host_d_valid & tl_h_i.d_ready;

  // Port assembly: pass-through by default, local error response while one is pending
  always_comb begin
    tl_d_o         = tl_h_i;
    tl_d_o.a_valid = dev_a_valid;
    tl_d_o.d_ready = dev_d_ready;

    tl_h_o         = tl_d_i;
    tl_h_o.a_ready = host_a_ready;
    if (err_pending) begin
      tl_h_o.d_valid  = 1'b1;
      tl_h_o.d_opcode = err_is_get ? TlAccessAckData : TlAccessAck;
      tl_h_o.d_param  = '0;
      tl_h_o.d_size   = err_size;
      tl_h_o.d_source = err_source;
      tl_h_o.d_sink   = 1'b0;
      tl_h_o.d_data   = '1;
      tl_h_o.d_user   = '0;
      tl_h_o.d_error  = 1'b1;
    end
  end

  // Outstanding device request counter; a stray response at zero leaves it at zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (dev_a_hs && !dev_d_hs) begin
      cnt <= cnt + 1'b1;
    end else if (dev_d_hs && !dev_a_hs && !cnt_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Error response flag: raised when a bad beat is absorbed, dropped when the host takes the response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_pending <= 1'b0;
    end else if (err_pending && host_d_hs) begin
      err_pending <= 1'b0;
    end else if (bad_accept) begin
      err_pending <= 1'b1;
    end
  end

  // Remember what the error response has to echo back to the host
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_source <= '0;
      err_size   <= '0;
      err_is_get <= 1'b0;
    end else if (bad_accept) begin
      err_source <= tl_h_i.a_source;
      err_size   <= tl_h_i.a_size;
      err_is_get <= (tl_h_i.a_opcode == TlGet);
    end
  end

  // Sanity checks on the counter window and on the device protocol
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (cnt <= CntMax);
      assert (!(tl_d_i.d_valid && cnt_zero));
    end
  end

endmodule

// File: tb/tb_llki_tlul_err_gate.sv
// Bench for llki_tlul_err_gate: directed scenarios followed by random traffic,
// all checked against an ordered response model and a simple device model.

module tb_llki_tlul_err_gate;

  localparam int MaxOut = 2;

  localparam logic [2:0] OpPutFull    = 3'h0;
  localparam logic [2:0] OpPutPartial = 3'h1;
  localparam logic [2:0] OpGet        = 3'h4;
  localparam logic [2:0] RspAck       = 3'h0;
  localparam logic [2:0] RspAckData   = 3'h1;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [63:0] data;
    logic        err;
    int          delay;
  } rsp_t;

  logic    clk_i = 1'b0;
  logic    rst_ni;
  logic    err_i;
  tl_h2d_t tl_h_i;
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_h_o;
  tl_d2h_t tl_d_i;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_cnt;
  bit          m_err;
  rsp_t        m_err_rsp;
  rsp_t        host_q[$];
  rsp_t        dev_q[$];
  bit          dev_en;
  int          dev_delay;
  bit          rand_delay;
  bit          dev_rand_err;
  logic [63:0] next_data;
  bit          use_next;
  bit          last_a_hs;

  always #5 clk_i = ~clk_i;

  llki_tlul_err_gate #(.MaxOutstanding(MaxOut)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_h_i (tl_h_i),
    .tl_h_o (tl_h_o),
    .err_i  (err_i),
    .tl_d_o (tl_d_o),
    .tl_d_i (tl_d_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                               input logic [7:0] mask, input logic [7:0] src, input logic err);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_param   = 3'h0;
    tl_h_i.a_size    = size;
    tl_h_i.a_source  = src;
    tl_h_i.a_address = addr;
    tl_h_i.a_mask    = mask;
    tl_h_i.a_data    = {$urandom, $urandom};
    tl_h_i.a_user    = 16'($urandom);
    err_i            = err;
    last_a_hs        = 1'b0;
  endtask

  // One clock cycle: drive the device side, check outputs, then advance the model
  task automatic stepCycle(input string tag);
    logic stall, exp_dav, exp_ardy, exp_hdv, exp_ddr;
    logic a_hs, dev_d_hs, host_d_hs;
    rsp_t r, e;
    tl_d_i.d_param = 3'($urandom);
    tl_d_i.d_sink  = 1'($urandom);
    tl_d_i.d_user  = 16'($urandom);
    if (dev_en && dev_q.size() > 0 && dev_q[0].delay == 0) begin
      tl_d_i.d_valid  = 1'b1;
      tl_d_i.d_opcode = dev_q[0].op;
      tl_d_i.d_size   = dev_q[0].size;
      tl_d_i.d_source = dev_q[0].src;
      tl_d_i.d_data   = dev_q[0].data;
      tl_d_i.d_error  = dev_q[0].err;
    end else begin
      tl_d_i.d_valid  = 1'b0;
      tl_d_i.d_opcode = 3'($urandom);
      tl_d_i.d_size   = 2'($urandom);
      tl_d_i.d_source = 8'($urandom);
      tl_d_i.d_data   = {$urandom, $urandom};
      tl_d_i.d_error  = 1'($urandom);
    end
    #2;
    stall   = m_err || (m_cnt == MaxOut);
    exp_dav = tl_h_i.a_valid && !err_i && !stall;
    if (tl_h_i.a_valid && err_i) exp_ardy = !m_err && (m_cnt == 0);
    else                         exp_ardy = tl_d_i.a_ready && !stall;
    exp_hdv = m_err || tl_d_i.d_valid;
    exp_ddr = !m_err && tl_h_i.d_ready;

    checkOutput({tag, " dev_a_valid"}, 64'(tl_d_o.a_valid), 64'(exp_dav));
    if (tl_h_i.a_valid) checkOutput({tag, " host_a_ready"}, 64'(tl_h_o.a_ready), 64'(exp_ardy));
    checkOutput({tag, " host_d_valid"}, 64'(tl_h_o.d_valid), 64'(exp_hdv));
    checkOutput({tag, " dev_d_ready"}, 64'(tl_d_o.d_ready), 64'(exp_ddr));
    checkOutput({tag, " cnt"}, 64'(dut.cnt), 64'(m_cnt));
    if (exp_dav) begin
      checkOutput({tag, " a_address"}, 64'(tl_d_o.a_address), 64'(tl_h_i.a_address));
      checkOutput({tag, " a_data"}, tl_d_o.a_data, tl_h_i.a_data);
      checkOutput({tag, " a_mask"}, 64'(tl_d_o.a_mask), 64'(tl_h_i.a_mask));
      checkOutput({tag, " a_source"}, 64'(tl_d_o.a_source), 64'(tl_h_i.a_source));
    end
    if (m_err) begin
      checkOutput({tag, " err_opcode"}, 64'(tl_h_o.d_opcode), 64'(m_err_rsp.op));
      checkOutput({tag, " err_source"}, 64'(tl_h_o.d_source), 64'(m_err_rsp.src));
      checkOutput({tag, " err_size"}, 64'(tl_h_o.d_size), 64'(m_err_rsp.size));
      checkOutput({tag, " err_data"}, tl_h_o.d_data, m_err_rsp.data);
      checkOutput({tag, " err_flag"}, 64'(tl_h_o.d_error), 64'(1'b1));
    end
    host_d_hs = exp_hdv && tl_h_i.d_ready;
    if (host_d_hs && host_q.size() > 0) begin
      e = host_q[0];
      checkOutput({tag, " rsp_opcode"}, 64'(tl_h_o.d_opcode), 64'(e.op));
      checkOutput({tag, " rsp_source"}, 64'(tl_h_o.d_source), 64'(e.src));
      checkOutput({tag, " rsp_size"}, 64'(tl_h_o.d_size), 64'(e.size));
      checkOutput({tag, " rsp_data"}, tl_h_o.d_data, e.data);
      checkOutput({tag, " rsp_error"}, 64'(tl_h_o.d_error), 64'(e.err));
      checkOutput({tag, " rsp_param"}, 64'(tl_h_o.d_param), m_err ? 64'(0) : 64'(tl_d_i.d_param));
      checkOutput({tag, " rsp_sink"}, 64'(tl_h_o.d_sink), m_err ? 64'(0) : 64'(tl_d_i.d_sink));
      checkOutput({tag, " rsp_user"}, 64'(tl_h_o.d_user), m_err ? 64'(0) : 64'(tl_d_i.d_user));
    end
    a_hs      = tl_h_i.a_valid && exp_ardy;
    dev_d_hs  = tl_d_i.d_valid && exp_ddr;
    last_a_hs = a_hs;

    @(posedge clk_i);
    if (!rst_ni) begin
      m_cnt = 0;
      m_err = 1'b0;
      host_q.delete();
      dev_q.delete();
    end else begin
      if (dev_d_hs && dev_q.size() > 0) begin
        void'(dev_q.pop_front());
        if (m_cnt > 0) m_cnt--;
      end
      if (host_d_hs && host_q.size() > 0) begin
        void'(host_q.pop_front());
        if (m_err) m_err = 1'b0;
      end
      if (dev_q.size() > 0 && dev_q[0].delay > 0) dev_q[0].delay = dev_q[0].delay - 1;
      if (a_hs) begin
        r.src  = tl_h_i.a_source;
        r.size = tl_h_i.a_size;
        r.op   = (tl_h_i.a_opcode == OpGet) ? RspAckData : RspAck;
        if (err_i) begin
          r.data    = '1;
          r.err     = 1'b1;
          r.delay   = 0;
          m_err     = 1'b1;
          m_err_rsp = r;
          host_q.push_back(r);
        end else begin
          r.data   = use_next ? next_data : {$urandom, $urandom};
          use_next = 1'b0;
          r.err    = dev_rand_err ? 1'($urandom) : 1'b0;
          r.delay  = rand_delay ? int'($urandom_range(0, 3)) : dev_delay;
          host_q.push_back(r);
          dev_q.push_back(r);
          m_cnt++;
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic holdUntilAccepted(input string tag, input int limit);
    for (int i = 0; i < limit && !last_a_hs; i++) stepCycle(tag);
    tl_h_i.a_valid = 1'b0;
  endtask

  // Directed scenarios, then random traffic, then summary
  initial begin
    logic [2:0] op;
    logic       bad;
    rst_ni       = 1'b0;
    err_i        = 1'b0;
    tl_h_i       = '0;
    tl_d_i       = '0;
    dev_en       = 1'b1;
    dev_delay    = 0;
    rand_delay   = 1'b0;
    dev_rand_err = 1'b0;
    use_next     = 1'b0;
    next_data    = '0;
    last_a_hs    = 1'b0;
    m_cnt        = 0;
    m_err        = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni         = 1'b1;
    tl_h_i.d_ready = 1'b1;
    tl_d_i.a_ready = 1'b1;
    stepCycle("reset");

    $display("[TB] good Get forwarded");
    next_data = 64'hDEADBEEF_CAFEF00D;
    use_next  = 1'b1;
    dev_delay = 1;
    applyStimulus(OpGet, 2'd3, 32'h10, 8'hFF, 8'd2, 1'b0);
    holdUntilAccepted("good_get", 4);
    repeat (4) stepCycle("good_get_rsp");

    $display("[TB] bad Get sunk");
    tl_h_i.d_ready = 1'b0;
    applyStimulus(OpGet, 2'd3, 32'h4, 8'hFF, 8'd5, 1'b1);
    holdUntilAccepted("bad_get", 4);
    applyStimulus(OpPutFull, 2'd3, 32'h20, 8'hFF, 8'd7, 1'b0);
    repeat (4) stepCycle("bad_get_hold");
    tl_h_i.d_ready = 1'b1;
    stepCycle("bad_get_retire");
    holdUntilAccepted("after_retire", 4);
    repeat (3) stepCycle("bad_get_drain");

    $display("[TB] bad PutFullData");
    applyStimulus(OpPutFull, 2'd3, 32'h30, 8'h0F, 8'd9, 1'b1);
    holdUntilAccepted("bad_put", 4);
    repeat (2) stepCycle("bad_put_rsp");

    $display("[TB] ordering");
    dev_delay = 3;
    applyStimulus(OpPutFull, 2'd3, 32'h40, 8'hFF, 8'd3, 1'b0);
    holdUntilAccepted("order_put", 4);
    applyStimulus(OpGet, 2'd2, 32'h44, 8'h0F, 8'd4, 1'b1);
    holdUntilAccepted("order_bad", 12);
    repeat (3) stepCycle("order_drain");

    $display("[TB] outstanding limit");
    dev_en    = 1'b0;
    dev_delay = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OpPutFull, 2'd3, 32'h100 + 32'(i * 8), 8'hFF, 8'(16 + i), 1'b0);
      stepCycle("limit_fill");
    end
    repeat (2) stepCycle("limit_stall");
    checkOutput("limit cnt", 64'(dut.cnt), 64'(2));
    checkOutput("limit dev_a_valid", 64'(tl_d_o.a_valid), 64'(0));
    dev_en = 1'b1;
    holdUntilAccepted("limit_release", 10);
    repeat (6) stepCycle("limit_drain");

    $display("[TB] reset mid-error");
    tl_h_i.d_ready = 1'b0;
    applyStimulus(OpGet, 2'd3, 32'h8, 8'hFF, 8'd6, 1'b1);
    holdUntilAccepted("rst_bad", 4);
    stepCycle("rst_pending");
    rst_ni = 1'b0;
    stepCycle("rst_assert");
    stepCycle("rst_held");
    checkOutput("rst d_valid", 64'(tl_h_o.d_valid), 64'(0));
    checkOutput("rst cnt", 64'(dut.cnt), 64'(0));
    rst_ni         = 1'b1;
    tl_h_i.d_ready = 1'b1;
    stepCycle("rst_release");

    $display("[TB] random traffic");
    rand_delay   = 1'b1;
    dev_rand_err = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!tl_h_i.a_valid || last_a_hs) begin
        if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 5))
            0, 1, 2: op = OpGet;
            3:       op = OpPutFull;
            4:       op = OpPutPartial;
            default: op = 3'($urandom);
          endcase
          bad = !(op == OpGet || op == OpPutFull || op == OpPutPartial) || ($urandom_range(0, 4) == 0);
          applyStimulus(op, 2'($urandom), $urandom, 8'($urandom), 8'($urandom), bad);
        end else begin
          tl_h_i.a_valid = 1'b0;
        end
      end
      tl_h_i.d_ready = ($urandom_range(0, 9) < 7);
      tl_d_i.a_ready = ($urandom_range(0, 9) < 7);
      dev_en         = ($urandom_range(0, 9) < 8);
      stepCycle("rand");
    end
    tl_h_i.a_valid = 1'b0;
    tl_h_i.d_ready = 1'b1;
    dev_en         = 1'b1;
    repeat (12) stepCycle("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
